lut_sweeper: RTL

LUT_SWEEPER -- requirements
Module: lut_sweeper

---
 rtl/lut_sweeper.sv | 105 ++++++++++
 1 files changed

// File: rtl/lut_sweeper.sv
// Programmable multi-output LUT with a handshaked full truth-table sweep and a single-vector evaluation port.
// Optional row parity output enabled by defining LUT_SWEEPER_PARITY_EN.
module lut_sweeper #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 3,
   localparam int DEPTH = 1 << N_IN,
   localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   input  logic [SEL_W-1:0]  cfg_sel,
   input  logic [DEPTH-1:0]  cfg_data,
   input  logic              start,
   output logic              busy,
   output logic              row_valid,
   input  logic              row_ready,
   output logic [N_IN-1:0]   row_idx,
   output logic [N_OUT-1:0]  row_out,
   output logic              done,
   input  logic              eval_valid,
   input  logic [N_IN-1:0]   eval_in,
   output logic              eval_out_valid,
`ifdef LUT_SWEEPER_PARITY_EN
   output logic              row_par,
`endif
   output logic [N_OUT-1:0]  eval_out
);

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

   state_t                        state;
   logic [N_OUT-1:0][DEPTH-1:0]   lut_reg;
   logic [N_OUT-1:0][DEPTH-1:0]   lut_next;
   logic [N_OUT-1:0]              row_first;
   logic [N_OUT-1:0]              row_step;
   logic [N_OUT-1:0]              eval_rd;
   logic [N_IN-1:0]               idx_inc;

   assign idx_inc = row_idx + 1'b1;

   // row_first looks through the same-cycle write so a start coinciding with cfg sees the new column.
   for (genvar gi = 0; gi < N_OUT; gi++) begin : g_col
      assign lut_next[gi]  = (cfg_valid && (cfg_sel == SEL_W'(gi))) ? cfg_data : lut_reg[gi];
      assign row_first[gi] = lut_next[gi][0];
      assign row_step[gi]  = lut_reg[gi][idx_inc];
      assign eval_rd[gi]   = lut_reg[gi][eval_in];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         busy           <= 1'b0;
         row_valid      <= 1'b0;
         row_idx        <= '0;
         row_out        <= '0;
         done           <= 1'b0;
         eval_out_valid <= 1'b0;
         eval_out       <= '0;
         lut_reg        <= '0;
      end else begin
         eval_out_valid <= eval_valid;
         if (eval_valid)
            eval_out <= eval_rd;

         case (state)
            IDLE: begin
               lut_reg <= lut_next;
               if (start) begin
                  state     <= SWEEP;
                  busy      <= 1'b1;
                  row_valid <= 1'b1;
                  row_idx   <= '0;
                  row_out   <= row_first;
               end
            end
            SWEEP: begin
               if (row_ready) begin
                  if (row_idx == LAST_IDX) begin
                     state     <= DONE;
                     row_valid <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     row_idx <= idx_inc;
                     row_out <= row_step;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LUT_SWEEPER_PARITY_EN
   assign row_par = ^row_out;
`endif

endmodule
